// File: rtl/gcd_pkg.sv
// Shared types for the GCD arbiter: FSM state encoding and the
// requester-ID width helper used by the interface, picker and top.
package gcd_pkg;

  typedef enum logic [2:0] {
    GCD_ARB_IDLE  = 3'd0,
    GCD_ARB_ISSUE = 3'd1,
    GCD_ARB_ARM   = 3'd2,
    GCD_ARB_WAIT  = 3'd3,
    GCD_ARB_RESP  = 3'd4
  } gcd_arb_state_e;

  // Width of a requester index; never less than one bit.
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gcd_arbiter_if.sv
// Client-side bundle of the GCD arbiter: per-requester request port
// (valid/ready plus packed operands) and the shared response port.
interface gcd_arbiter_if
  import gcd_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 32,
  parameter int ID_W  = id_w(N_REQ)
) ();

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [W-1:0]       rsp_result;

  // Client logic side.
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result
  );

endinterface

// File: rtl/gcd_rr_picker.sv
// Combinational round-robin selector: starting one past the last grant
// and wrapping, pick the first requester with valid high.
module gcd_rr_picker
  import gcd_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid_i,
  input  logic [ID_W-1:0]  last_grant_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  grant_idx_o,
  output logic             any_valid_o
);

  // Scan N_REQ positions after last_grant; the first valid one wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_o     = '0;
    grant_idx_o = '0;
    any_valid_o = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant_i) + k) % N_REQ;
      if (!any_valid_o && req_valid_i[idx]) begin
        any_valid_o  = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin front end sharing one GCD engine among N_REQ requesters.
// Optional build macro GCD_ARB_BYPASS_EN: requests with a zero operand
// are answered directly (result = the nonzero operand) without the engine.
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  gcd_arbiter_if.slave  bus,
  output logic          eng_start,
  output logic [W-1:0]  eng_a,
  output logic [W-1:0]  eng_b,
  input  logic          eng_done,
  input  logic [W-1:0]  eng_result,
  output logic          busy
);

  localparam int ID_W = id_w(N_REQ);

  gcd_arb_state_e  state_q, state_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [ID_W-1:0] cur_id_q, cur_id_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]    eng_a_q, eng_a_d;
  logic [W-1:0]    eng_b_q, eng_b_d;
  logic [W-1:0]    rsp_result_q, rsp_result_d;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             any_valid;
  logic             idle_pick;
  int               sel_base;
  logic [W-1:0]     sel_a, sel_b;

  gcd_rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req_valid_i  (bus.req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx),
    .any_valid_o  (any_valid)
  );

  assign sel_base  = int'(grant_idx) * W;
  assign sel_a     = bus.req_a[sel_base +: W];
  assign sel_b     = bus.req_b[sel_base +: W];
  assign idle_pick = (state_q == GCD_ARB_IDLE) && any_valid;

  // req_ready is gated by reset so it reads 0 while reset is held.
  assign bus.req_ready  = (idle_pick && reset_n) ? grant : '0;
  assign bus.rsp_valid  = (state_q == GCD_ARB_RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign eng_start      = (state_q == GCD_ARB_ISSUE);
  assign eng_a          = eng_a_q;
  assign eng_b          = eng_b_q;
  assign busy           = (state_q != GCD_ARB_IDLE);

  // Next-state and register-update logic for the grant/engine/response sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cur_id_d     = cur_id_q;
    rsp_id_d     = rsp_id_q;
    eng_a_d      = eng_a_q;
    eng_b_d      = eng_b_q;
    rsp_result_d = rsp_result_q;
    unique case (state_q)
      GCD_ARB_IDLE: begin
        if (any_valid) begin
          cur_id_d = grant_idx;
`ifdef GCD_ARB_BYPASS_EN
          if ((sel_a == '0) || (sel_b == '0)) begin
            // gcd(x,0) = x; OR yields the nonzero operand (or 0 for 0,0).
            rsp_result_d = sel_a | sel_b;
            rsp_id_d     = grant_idx;
            state_d      = GCD_ARB_RESP;
          end else begin
            eng_a_d = sel_a;
            eng_b_d = sel_b;
            state_d = GCD_ARB_ISSUE;
          end
`else
          eng_a_d = sel_a;
          eng_b_d = sel_b;
          state_d = GCD_ARB_ISSUE;
`endif
        end
      end
      GCD_ARB_ISSUE: state_d = GCD_ARB_ARM;
      // eng_done may still be high from the previous operation here.
      GCD_ARB_ARM:   state_d = GCD_ARB_WAIT;
      GCD_ARB_WAIT: begin
        if (eng_done) begin
          rsp_result_d = eng_result;
          rsp_id_d     = cur_id_q;
          state_d      = GCD_ARB_RESP;
        end
      end
      GCD_ARB_RESP: begin
        if (bus.rsp_ready) begin
          last_grant_d = cur_id_q;
          state_d      = GCD_ARB_IDLE;
        end
      end
      default: state_d = GCD_ARB_IDLE;
    endcase
  end

  // State and datapath registers; last_grant resets so requester 0 wins first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= GCD_ARB_IDLE;
      last_grant_q <= ID_W'(N_REQ - 1);
      cur_id_q     <= '0;
      rsp_id_q     <= '0;
      eng_a_q      <= '0;
      eng_b_q      <= '0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cur_id_q     <= cur_id_d;
      rsp_id_q     <= rsp_id_d;
      eng_a_q      <= eng_a_d;
      eng_b_q      <= eng_b_d;
      rsp_result_q <= rsp_result_d;
    end
  end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Self-checking bench for gcd_arbiter: directed table, multi-cycle corner
// sequences and randomized traffic against a transaction-level model.
module tb_gcd_arbiter;
  import gcd_pkg::*;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int IDW = id_w(N);
`ifdef GCD_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  gcd_arbiter_if #(.N_REQ(N), .W(W)) bus ();

  logic         eng_start;
  logic [W-1:0] eng_a, eng_b;
  logic         eng_done;
  logic [W-1:0] eng_result;
  logic         busy;

  gcd_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .eng_start  (eng_start),
    .eng_a      (eng_a),
    .eng_b      (eng_b),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .busy       (busy)
  );

  function automatic logic [W-1:0] gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  // Engine model: done drops one edge after start is taken (worst case the
  // contract allows), result/done appear eng_lat edges after start.
  int           eng_lat = 3;
  logic         pre_req = 1'b0;
  logic [W-1:0] pre_val = '0;
  int           e_cnt;
  logic         e_clr;
  logic [W-1:0] e_pend;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eng_done <= 1'b0; eng_result <= '0; e_cnt <= 0; e_clr <= 1'b0; e_pend <= '0;
    end else if (eng_start) begin
      e_cnt <= eng_lat; e_clr <= 1'b1; e_pend <= gcd(eng_a, eng_b);
    end else if (pre_req) begin
      eng_done <= 1'b1; eng_result <= pre_val;
    end else begin
      if (e_clr) begin eng_done <= 1'b0; e_clr <= 1'b0; end
      if (e_cnt != 0) e_cnt <= e_cnt - 1;
      if (e_cnt == 1) begin eng_done <= 1'b1; eng_result <= e_pend; end
    end
  end

  int n_cmp = 0;
  int n_fail = 0;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle-time %0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference state.
  int           cyc = 0;
  bit           m_busy = 1'b0;
  int           m_last = N - 1;
  int           m_id, m_acc, m_lat;
  bit           m_byp;
  logic [W-1:0] m_a, m_b, m_res;
  bit           acc_seen, rsp_seen;
  int           acc_id, rsp_got_id, n_starts;
  logic [W-1:0] rsp_got_res;

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic monitor();
    bit           exp_start, exp_rv, hs;
    int           g;
    logic [N-1:0] exp_g;
    if (!reset_n) return;
    hs = 1'b0;
    if (eng_start) n_starts++;
    exp_start = m_busy && !m_byp && (cyc == m_acc + 1);
    check("eng_start", eng_start, exp_start);
    if (exp_start && eng_start) begin
      check("eng_a", eng_a, m_a);
      check("eng_b", eng_b, m_b);
    end
    exp_rv = m_busy && (cyc >= m_acc + (m_byp ? 1 : m_lat + 3));
    check("rsp_valid", bus.rsp_valid, exp_rv);
    if (exp_rv && bus.rsp_valid) begin
      check("rsp_id", bus.rsp_id, m_id);
      check("rsp_result", bus.rsp_result, m_res);
      if (bus.rsp_ready) begin
        hs = 1'b1; rsp_seen = 1'b1; rsp_got_id = int'(bus.rsp_id); rsp_got_res = bus.rsp_result;
      end
    end
    check("busy", busy, m_busy);
    if (m_busy || bus.req_valid == '0) begin
      check("req_ready_zero", bus.req_ready, '0);
    end else begin
      g = rr_pick(m_last, bus.req_valid);
      exp_g = '0;
      exp_g[g] = 1'b1;
      check("grant", bus.req_ready, exp_g);
      m_busy = 1'b1; m_id = g; m_acc = cyc; m_lat = eng_lat;
      m_a = bus.req_a[g*W +: W]; m_b = bus.req_b[g*W +: W];
      m_byp = BYP && (m_a == 0 || m_b == 0);
      m_res = m_byp ? (m_a | m_b) : gcd(m_a, m_b);
      acc_seen = 1'b1; acc_id = g;
    end
    if (hs) begin m_busy = 1'b0; m_last = m_id; end
  endtask

  task automatic step();
    #1; monitor();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic wait_acc(input string nm);
    int k = 0;
    while (!acc_seen && k < 40) begin step(); k++; end
    check(nm, acc_seen, 1'b1);
  endtask

  task automatic wait_rsp(input string nm);
    int k = 0;
    while (!rsp_seen && k < 60) begin step(); k++; end
    check(nm, rsp_seen, 1'b1);
  endtask

  task automatic set_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a[id*W +: W] = a;
    bus.req_b[id*W +: W] = b;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m_busy = 1'b0; m_last = N - 1;
    repeat (2) @(posedge clk);
    #1; reset_n = 1'b1;
  endtask

  typedef struct {int id; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] exp;} vec_t;
  vec_t vt[7];
  int   exp_order[5];

  initial begin
    int           starts0;
    int           h_id;
    logic [W-1:0] h_res;
    logic [N-1:0] v;

    vt[0] = '{1, 48, 18, 6};
    vt[1] = '{0, 35, 14, 7};
    vt[2] = '{3, 100, 75, 25};
    vt[3] = '{2, 17, 5, 1};
    vt[4] = '{1, 0, 21, 21};
    vt[5] = '{0, 12, 0, 12};
    vt[6] = '{3, 1071, 462, 21};
    exp_order = '{0, 1, 2, 3, 0};

    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, '0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_id", bus.rsp_id, '0);
    check("rst_rsp_result", bus.rsp_result, '0);
    check("rst_eng_start", eng_start, 1'b0);
    check("rst_eng_a", eng_a, '0);
    check("rst_eng_b", eng_b, '0);
    check("rst_busy", busy, 1'b0);
    reset_n = 1'b1;

    // All requesters held valid from reset: strict rotation 0,1,2,3,0.
    for (int i = 0; i < N; i++) set_op(i, 12 * (i + 1), 8);
    bus.req_valid = '1; bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      acc_seen = 1'b0;
      wait_acc("order_timeout");
      check("grant_order", acc_id, exp_order[i]);
    end
    bus.req_valid = '0;
    rsp_seen = 1'b0;
    wait_rsp("order_rsp_timeout");

    // Directed table, one request at a time.
    for (int i = 0; i < 7; i++) begin
      set_op(vt[i].id, vt[i].a, vt[i].b);
      v = '0; v[vt[i].id] = 1'b1;
      bus.req_valid = v;
      acc_seen = 1'b0; rsp_seen = 1'b0; starts0 = n_starts;
      wait_acc("vec_acc_timeout");
      bus.req_valid = '0;
      wait_rsp("vec_rsp_timeout");
      check("vec_id", rsp_got_id, vt[i].id);
      check("vec_result", rsp_got_res, vt[i].exp);
      check("vec_starts", n_starts - starts0,
            (BYP && (vt[i].a == 0 || vt[i].b == 0)) ? 0 : 1);
    end

    // Response back-pressure: 5 cycles with rsp_ready low, requester 3 waiting.
    bus.rsp_ready = 1'b0;
    set_op(2, 30, 12); set_op(3, 45, 27);
    bus.req_valid = 4'b0100;
    acc_seen = 1'b0; rsp_seen = 1'b0;
    wait_acc("hold_acc_timeout");
    bus.req_valid = 4'b1000;
    for (int k = 0; k < 40 && !bus.rsp_valid; k++) step();
    check("hold_rsp_seen", bus.rsp_valid, 1'b1);
    h_id = int'(bus.rsp_id); h_res = bus.rsp_result;
    check("hold_first_result", h_res, 6);
    for (int k = 0; k < 5; k++) begin
      step();
      check("hold_valid", bus.rsp_valid, 1'b1);
      check("hold_id", bus.rsp_id, h_id);
      check("hold_result", bus.rsp_result, h_res);
      check("hold_no_ready", bus.req_ready, '0);
    end
    bus.rsp_ready = 1'b1;
    acc_seen = 1'b0;
    wait_acc("hold_next_timeout");
    bus.req_valid = '0;
    check("hold_next_id", acc_id, 3);
    check("hold_rsp_id", rsp_got_id, 2);
    rsp_seen = 1'b0;
    wait_rsp("hold_next_rsp_timeout");
    check("hold_next_result", rsp_got_res, 9);

    // Stale done left high by the engine: old result 7, then old result 9.
    for (int r = 0; r < 2; r++) begin
      pre_val = (r == 0) ? 7 : 9;
      pre_req = 1'b1; step(); pre_req = 1'b0;
      eng_lat = 5;
      set_op(0, 35, 14); bus.req_valid = 4'b0001;
      acc_seen = 1'b0; rsp_seen = 1'b0;
      wait_acc("stale_acc_timeout");
      bus.req_valid = '0;
      wait_rsp("stale_rsp_timeout");
      check("stale_result", rsp_got_res, 7);
    end

    // Reset while waiting on the engine.
    eng_lat = 6;
    set_op(1, 48, 18); bus.req_valid = 4'b0010;
    acc_seen = 1'b0;
    wait_acc("mid_acc_timeout");
    bus.req_valid = '0;
    repeat (3) step();
    reset_n = 1'b0;
    bus.req_valid = 4'b0101;
    set_op(0, 9, 6); set_op(2, 8, 4);
    #1;
    check("mid_req_ready", bus.req_ready, '0);
    check("mid_rsp_valid", bus.rsp_valid, 1'b0);
    check("mid_rsp_id", bus.rsp_id, '0);
    check("mid_rsp_result", bus.rsp_result, '0);
    check("mid_eng_start", eng_start, 1'b0);
    check("mid_eng_a", eng_a, '0);
    check("mid_eng_b", eng_b, '0);
    check("mid_busy", busy, 1'b0);
    m_busy = 1'b0; m_last = N - 1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    acc_seen = 1'b0;
    wait_acc("post_rst_timeout");
    check("post_rst_first", acc_id, 0);
    acc_seen = 1'b0;
    wait_acc("post_rst_second_timeout");
    check("post_rst_second", acc_id, 2);
    bus.req_valid = '0;
    rsp_seen = 1'b0;
    wait_rsp("post_rst_rsp_timeout");

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      bus.req_valid = N'($urandom);
      for (int i = 0; i < N; i++)
        set_op(i, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 60) * $urandom_range(1, 12),
                  ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 60) * $urandom_range(1, 12));
      bus.rsp_ready = $urandom_range(0, 1);
      if (!m_busy) eng_lat = $urandom_range(2, 6);
      step();
    end
    bus.req_valid = '0; bus.rsp_ready = 1'b1;
    for (int k = 0; k < 40 && m_busy; k++) step();
    check("drain_idle", m_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
